// File: rtl/mem_array_dp_pkg.sv
// Shared types and helpers for the dual-port memory array and its clear sequencer.
package mem_array_dp_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } seq_state_e;

    localparam int DEFAULT_LANE_WIDTH = 8;

    function automatic int num_lanes(input int word_width, input int lane_width);
        return word_width / lane_width;
    endfunction

endpackage

// File: rtl/mem_array_dp_clear_seq.sv
// CLEAR/RUN sequencer: walks a pointer over every word after reset or a clear
// request, and flags the array as busy while it does so.
module mem_clear_seq
    import mem_array_dp_pkg::*;
#(
    parameter int ADDR_WIDTH = 2,
    parameter int WORD_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    output logic                  clr_active_o,
    output logic [ADDR_WIDTH-1:0] clr_adrs_o,
    output logic                  busy_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADRS = ADDR_WIDTH'(WORD_DEPTH - 1);

    seq_state_e            state_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic                  busy_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (ptr_q == LAST_ADRS) begin
                        state_q <= ST_RUN;
                        ptr_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clr_i) begin
                        state_q <= ST_CLEAR;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign clr_active_o = (state_q == ST_CLEAR);
    assign clr_adrs_o   = ptr_q;
    assign busy_o       = busy_q;

endmodule

// File: rtl/mem_array_dp.sv
// Simple-dual-port synchronous RAM with lane write enables, write-first
// bypass, out-of-range protection and a hardware clear sequence.
module mem_array_dp
    import mem_array_dp_pkg::*;
#(
    parameter int  ADDR_WIDTH = 2,
    parameter int  WORD_DEPTH = 4,
    parameter int  WORD_WIDTH = 8,
    parameter int  LANE_WIDTH = DEFAULT_LANE_WIDTH,
    localparam int NUM_LANES  = num_lanes(WORD_WIDTH, LANE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_adrs_i,
    input  logic [NUM_LANES-1:0]  wr_lanes_i,
    input  logic [WORD_WIDTH-1:0] d_in_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_adrs_i,
    output logic [WORD_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  busy_o
);

    generate
        if (WORD_WIDTH % LANE_WIDTH != 0) begin : g_bad_lane_width
            $error("mem_array_dp: WORD_WIDTH must be a multiple of LANE_WIDTH");
        end
        if (WORD_DEPTH < 1 || WORD_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_word_depth
            $error("mem_array_dp: WORD_DEPTH must lie in 1..2**ADDR_WIDTH");
        end
    endgenerate

    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(WORD_DEPTH);

    logic                  clr_active;
    logic [ADDR_WIDTH-1:0] clr_adrs;

    mem_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WORD_DEPTH (WORD_DEPTH)
    ) u_clear_seq (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (clr_i),
        .clr_active_o (clr_active),
        .clr_adrs_o   (clr_adrs),
        .busy_o       (busy_o)
    );

    logic [WORD_WIDTH-1:0] mem_q [WORD_DEPTH];

    logic                  access_ok;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  rd_in_range;
    logic [WORD_WIDTH-1:0] wr_word;
    logic [WORD_WIDTH-1:0] rd_data_d, rd_data_q;
    logic                  rd_valid_d, rd_valid_q;

    // A clear request in RUN wins over any access sampled on the same edge.
    assign access_ok   = !clr_active && !clr_i;
    assign wr_fire     = access_ok && wr_en_i && ({1'b0, wr_adrs_i} < DEPTH_EXT);
    assign rd_fire     = access_ok && rd_en_i;
    assign rd_in_range = ({1'b0, rd_adrs_i} < DEPTH_EXT);

    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        wr_word = mem_q[wr_adrs_i];
        for (int i = 0; i < NUM_LANES; i++) begin
            if (wr_lanes_i[i]) begin
                wr_word[i*LANE_WIDTH +: LANE_WIDTH] = d_in_i[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    // Write-first: a same-address read sees the merged word being written.
    always_comb begin
        rd_valid_d = rd_fire;
        rd_data_d  = rd_data_q;
        if (rd_fire) begin
            if (!rd_in_range) begin
                rd_data_d = '0;
            end else if (wr_fire && (wr_adrs_i == rd_adrs_i)) begin
                rd_data_d = wr_word;
            end else begin
                rd_data_d = mem_q[rd_adrs_i];
            end
        end
    end

    // NOTE: the storage array has no reset so it maps onto RAM; the clear
    // sequencer zeroes it one word per cycle instead.
    always_ff @(posedge clk) begin
        if (clr_active) begin
            mem_q[clr_adrs] <= '0;
        end else if (wr_fire) begin
            mem_q[wr_adrs_i] <= wr_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_mem_array_dp.sv
// Self-checking bench: a 4x8 instance and a 5x32 (4-lane) instance share the
// clock and reset and are compared against a word-level model of each.
module tb_mem_array_dp;

    typedef struct {
        bit       clr;
        bit       wr_en;
        int       wr_adrs;
        bit [3:0] lanes;
        bit [31:0] din;
        bit       rd_en;
        int       rd_adrs;
    } stim_t;

    localparam int DEP [2] = '{4, 5};
    localparam int NL  [2] = '{1, 4};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       a_clr = 0, a_wr_en = 0, a_rd_en = 0;
    logic [1:0] a_wr_adrs = '0, a_rd_adrs = '0;
    logic [0:0] a_wr_lanes = '0;
    logic [7:0] a_d_in = '0;
    logic [7:0] a_rd_data;
    logic       a_rd_valid, a_busy;

    logic        b_clr = 0, b_wr_en = 0, b_rd_en = 0;
    logic [2:0]  b_wr_adrs = '0, b_rd_adrs = '0;
    logic [3:0]  b_wr_lanes = '0;
    logic [31:0] b_d_in = '0;
    logic [31:0] b_rd_data;
    logic        b_rd_valid, b_busy;

    mem_array_dp #(.ADDR_WIDTH(2), .WORD_DEPTH(4), .WORD_WIDTH(8), .LANE_WIDTH(8)) dut_a (
        .clk(clk), .rst(rst), .clr_i(a_clr), .wr_en_i(a_wr_en), .wr_adrs_i(a_wr_adrs),
        .wr_lanes_i(a_wr_lanes), .d_in_i(a_d_in), .rd_en_i(a_rd_en), .rd_adrs_i(a_rd_adrs),
        .rd_data_o(a_rd_data), .rd_valid_o(a_rd_valid), .busy_o(a_busy)
    );

    mem_array_dp #(.ADDR_WIDTH(3), .WORD_DEPTH(5), .WORD_WIDTH(32), .LANE_WIDTH(8)) dut_b (
        .clk(clk), .rst(rst), .clr_i(b_clr), .wr_en_i(b_wr_en), .wr_adrs_i(b_wr_adrs),
        .wr_lanes_i(b_wr_lanes), .d_in_i(b_d_in), .rd_en_i(b_rd_en), .rd_adrs_i(b_rd_adrs),
        .rd_data_o(b_rd_data), .rd_valid_o(b_rd_valid), .busy_o(b_busy)
    );

    // Reference model: word storage, words still to clear, and the read port.
    logic [31:0] m_mem [2][8];
    int          m_clear_left [2];
    logic [31:0] m_rd_data [2];
    logic        m_rd_valid [2];

    int vectors     = 0;
    int miscompares = 0;

    function automatic stim_t idle_stim();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic stim_t wr_stim(input int adrs, input bit [3:0] lanes, input bit [31:0] din);
        stim_t s;
        s = idle_stim();
        s.wr_en = 1; s.wr_adrs = adrs; s.lanes = lanes; s.din = din;
        return s;
    endfunction

    function automatic stim_t rd_stim(input int adrs);
        stim_t s;
        s = idle_stim();
        s.rd_en = 1; s.rd_adrs = adrs;
        return s;
    endfunction

    task automatic model_edge(input int s, input stim_t st);
        if (m_clear_left[s] > 0) begin
            m_mem[s][DEP[s] - m_clear_left[s]] = '0;
            m_clear_left[s]--;
            m_rd_valid[s] = 0;
        end else if (st.clr) begin
            m_clear_left[s] = DEP[s];
            m_rd_valid[s]   = 0;
        end else begin
            if (st.wr_en && st.wr_adrs < DEP[s]) begin
                for (int i = 0; i < NL[s]; i++) begin
                    if (st.lanes[i]) m_mem[s][st.wr_adrs][i*8 +: 8] = st.din[i*8 +: 8];
                end
            end
            m_rd_valid[s] = st.rd_en;
            if (st.rd_en) m_rd_data[s] = (st.rd_adrs < DEP[s]) ? m_mem[s][st.rd_adrs] : 32'h0;
        end
    endtask

    task automatic tick(input stim_t sa, input stim_t sb);
        a_clr = sa.clr; a_wr_en = sa.wr_en; a_wr_adrs = 2'(sa.wr_adrs); a_wr_lanes = sa.lanes[0];
        a_d_in = sa.din[7:0]; a_rd_en = sa.rd_en; a_rd_adrs = 2'(sa.rd_adrs);
        b_clr = sb.clr; b_wr_en = sb.wr_en; b_wr_adrs = 3'(sb.wr_adrs); b_wr_lanes = sb.lanes;
        b_d_in = sb.din; b_rd_en = sb.rd_en; b_rd_adrs = 3'(sb.rd_adrs);
        @(posedge clk);
        model_edge(0, sa);
        model_edge(1, sb);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            m_clear_left[s] = DEP[s];
            m_rd_valid[s]   = 0;
            m_rd_data[s]    = '0;
        end
        #1;
        vectors++;
        if (a_rd_data !== 8'h00 || a_rd_valid !== 1'b0 || a_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_a: got data=%h valid=%b busy=%b, want 00/0/1", a_rd_data, a_rd_valid, a_busy);
        end
        vectors++;
        if (b_rd_data !== 32'h0 || b_rd_valid !== 1'b0 || b_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_b: got data=%h valid=%b busy=%b, want 0/0/1", b_rd_data, b_rd_valid, b_busy);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int e = 1; e <= 5; e++) begin
            tick(idle_stim(), idle_stim());
            vectors++;
            if (a_busy !== (e < 4)) begin
                miscompares++;
                $display("FAIL busy_a edge %0d: got %b want %b", e, a_busy, (e < 4));
            end
            vectors++;
            if (b_busy !== (e < 5)) begin
                miscompares++;
                $display("FAIL busy_b edge %0d: got %b want %b", e, b_busy, (e < 5));
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick(rd_stim(i), idle_stim());
            vectors++;
            if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h00) begin
                miscompares++;
                $display("FAIL post_reset_read[%0d]: got %b/%h want 1/00", i, a_rd_valid, a_rd_data);
            end
        end
    endtask

    task automatic test_write_read();
        tick(wr_stim(2, 4'b0001, 32'hA5), idle_stim());
        tick(rd_stim(2), idle_stim());
        vectors++;
        if (a_rd_valid !== 1'b1 || a_rd_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL write_read: got %b/%h want 1/a5", a_rd_valid, a_rd_data);
        end
        tick(idle_stim(), idle_stim());
        vectors++;
        if (a_rd_valid !== 1'b0 || a_rd_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL read_hold: got %b/%h want 0/a5", a_rd_valid, a_rd_data);
        end
    endtask

    task automatic test_lane_merge();
        tick(idle_stim(), wr_stim(1, 4'b1111, 32'h11223344));
        tick(idle_stim(), wr_stim(1, 4'b0101, 32'hAABBCCDD));
        tick(idle_stim(), rd_stim(1));
        vectors++;
        if (b_rd_valid !== 1'b1 || b_rd_data !== 32'h11BB33DD) begin
            miscompares++;
            $display("FAIL lane_merge: got %b/%h want 1/11bb33dd", b_rd_valid, b_rd_data);
        end
        tick(idle_stim(), wr_stim(1, 4'b0000, 32'hFFFFFFFF));
        tick(idle_stim(), rd_stim(1));
        vectors++;
        if (b_rd_data !== 32'h11BB33DD) begin
            miscompares++;
            $display("FAIL lane_none: got %h want 11bb33dd", b_rd_data);
        end
    endtask

    task automatic test_collision();
        stim_t s;
        tick(wr_stim(3, 4'b0001, 32'h0F), idle_stim());
        s = wr_stim(3, 4'b0001, 32'hF0);
        s.rd_en = 1; s.rd_adrs = 3;
        tick(s, idle_stim());
        vectors++;
        if (a_rd_valid !== 1'b1 || a_rd_data !== 8'hF0) begin
            miscompares++;
            $display("FAIL collision: got %b/%h want 1/f0", a_rd_valid, a_rd_data);
        end
        s = wr_stim(3, 4'b0000, 32'h33);
        s.rd_en = 1; s.rd_adrs = 3;
        tick(s, idle_stim());
        vectors++;
        if (a_rd_data !== 8'hF0) begin
            miscompares++;
            $display("FAIL collision_no_lane: got %h want f0", a_rd_data);
        end
    endtask

    task automatic test_out_of_range();
        for (int i = 0; i < 5; i++) tick(idle_stim(), wr_stim(i, 4'b1111, $urandom));
        tick(idle_stim(), wr_stim(6, 4'b1111, 32'hDEADBEEF));
        tick(idle_stim(), rd_stim(6));
        vectors++;
        if (b_rd_valid !== 1'b1 || b_rd_data !== 32'h0) begin
            miscompares++;
            $display("FAIL oor_read: got %b/%h want 1/0", b_rd_valid, b_rd_data);
        end
        for (int i = 0; i < 5; i++) begin
            tick(idle_stim(), rd_stim(i));
            vectors++;
            if (b_rd_valid !== 1'b1 || b_rd_data !== m_mem[1][i]) begin
                miscompares++;
                $display("FAIL oor_intact[%0d]: got %h want %h", i, b_rd_data, m_mem[1][i]);
            end
        end
    endtask

    task automatic test_clear();
        stim_t s;
        tick(wr_stim(1, 4'b0001, 32'h33), idle_stim());
        s = wr_stim(0, 4'b0001, 32'h55);
        s.clr = 1; s.rd_en = 1; s.rd_adrs = 1;
        tick(s, idle_stim());
        vectors++;
        if (a_busy !== 1'b1 || a_rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_edge: got busy=%b valid=%b want 1/0", a_busy, a_rd_valid);
        end
        for (int e = 1; e <= 4; e++) begin
            tick(idle_stim(), idle_stim());
            vectors++;
            if (a_busy !== (e < 4)) begin
                miscompares++;
                $display("FAIL clr_busy edge %0d: got %b want %b", e, a_busy, (e < 4));
            end
        end
        tick(rd_stim(0), idle_stim());
        vectors++;
        if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h00) begin
            miscompares++;
            $display("FAIL clr_dropped_write: got %b/%h want 1/00", a_rd_valid, a_rd_data);
        end
        tick(wr_stim(2, 4'b0001, 32'h77), idle_stim());
        s = idle_stim();
        s.clr = 1;
        tick(s, idle_stim());
        tick(idle_stim(), idle_stim());
        tick(idle_stim(), idle_stim());
        do_reset();
        for (int e = 1; e <= 4; e++) begin
            tick(idle_stim(), idle_stim());
            vectors++;
            if (a_busy !== (e < 4)) begin
                miscompares++;
                $display("FAIL rst_restart_busy edge %0d: got %b want %b", e, a_busy, (e < 4));
            end
        end
        tick(idle_stim(), idle_stim());
        for (int i = 0; i < 4; i++) begin
            tick(rd_stim(i), idle_stim());
            vectors++;
            if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h00) begin
                miscompares++;
                $display("FAIL clr_zero[%0d]: got %b/%h want 1/00", i, a_rd_valid, a_rd_data);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t sa, sb;
        for (int n = 0; n < 400; n++) begin
            sa.clr = ($urandom_range(49) == 0); sa.wr_en = $urandom_range(1);
            sa.wr_adrs = $urandom_range(3); sa.lanes = 4'($urandom_range(1)); sa.din = $urandom;
            sa.rd_en = $urandom_range(1);
            sa.rd_adrs = ($urandom_range(2) == 0) ? sa.wr_adrs : $urandom_range(3);
            sb.clr = ($urandom_range(49) == 0); sb.wr_en = $urandom_range(1);
            sb.wr_adrs = $urandom_range(7); sb.lanes = 4'($urandom_range(15)); sb.din = $urandom;
            sb.rd_en = $urandom_range(1);
            sb.rd_adrs = ($urandom_range(2) == 0) ? sb.wr_adrs : $urandom_range(7);
            tick(sa, sb);
            vectors++;
            if (a_rd_valid !== m_rd_valid[0] || a_rd_data !== m_rd_data[0][7:0] ||
                a_busy !== (m_clear_left[0] > 0)) begin
                miscompares++;
                $display("FAIL random_a cycle %0d: got %b/%h/%b want %b/%h/%b", n, a_rd_valid,
                         a_rd_data, a_busy, m_rd_valid[0], m_rd_data[0][7:0], (m_clear_left[0] > 0));
            end
            vectors++;
            if (b_rd_valid !== m_rd_valid[1] || b_rd_data !== m_rd_data[1] ||
                b_busy !== (m_clear_left[1] > 0)) begin
                miscompares++;
                $display("FAIL random_b cycle %0d: got %b/%h/%b want %b/%h/%b", n, b_rd_valid,
                         b_rd_data, b_busy, m_rd_valid[1], m_rd_data[1], (m_clear_left[1] > 0));
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_write_read();
        test_lane_merge();
        test_collision();
        test_out_of_range();
        test_clear();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
